// File: rtl/idelay_tap_ctrl_if.sv
// Command/response bus between a tap-control client and idelay_tap_ctrl.
interface idelay_tap_ctrl_if;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [1:0] CMD_OP;
  logic [4:0] CMD_ARG;
  logic       RSP_VALID;
  logic [4:0] RSP_TAP;
  logic       RSP_SAT;
  logic       RSP_MISMATCH;

  modport master (
    output CMD_VALID, CMD_OP, CMD_ARG,
    input  CMD_READY, RSP_VALID, RSP_TAP, RSP_SAT, RSP_MISMATCH
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_ARG,
    output CMD_READY, RSP_VALID, RSP_TAP, RSP_SAT, RSP_MISMATCH
  );
endinterface

// File: rtl/idelay_tap_ctrl.sv
// IDELAYE2 VAR_LOAD tap controller: load/inc/dec/read commands, one tap step
// at a time with settle waits, saturating tap tracking and a one-cycle response.
module idelay_tap_ctrl #(
  parameter int unsigned INIT_TAP      = 0,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                C,
  input  logic                RSTN,
  idelay_tap_ctrl_if.slave    bus,
  output logic                DLY_CE,
  output logic                DLY_INC,
  output logic                DLY_LD,
  output logic [4:0]          DLY_CNTVALUEIN,
  input  logic [4:0]          DLY_CNTVALUEOUT,
  output logic [4:0]          TAP
);

  localparam int unsigned TAP_W = 5;
  localparam int unsigned CNT_W = 8;
  localparam logic [TAP_W-1:0] TAP_MAX  = 5'd31;
  localparam logic [TAP_W-1:0] TAP_INIT = TAP_W'(INIT_TAP);
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_INC  = 2'd1;
  localparam logic [1:0] OP_DEC  = 2'd2;
  localparam logic [1:0] OP_READ = 2'd3;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOAD, S_STEP, S_SETTLE, S_RESP} state_e;
  typedef enum logic [1:0] {RET_IDLE, RET_RESP, RET_STEP} ret_e;

  state_e             state_q, state_d;
  ret_e               ret_q, ret_d;
  logic [TAP_W-1:0]   tap_q, tap_d;
  logic [TAP_W-1:0]   rem_q, rem_d;
  logic               up_q, up_d;
  logic               sat_q, sat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               ce_q, ce_d;
  logic               dinc_q, dinc_d;
  logic               ld_q, ld_d;
  logic [TAP_W-1:0]   cntin_q, cntin_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [TAP_W-1:0]   rsp_tap_q, rsp_tap_d;
  logic               rsp_sat_q, rsp_sat_d;
  logic               rsp_mis_q, rsp_mis_d;

  logic               go_step;
  logic               leave;
  logic               handshake;
  logic [TAP_W-1:0]   step_rem;
  logic               step_up;
  logic               at_bound;

  assign handshake = bus.CMD_VALID & ready_q;
  assign step_rem  = (state_q == S_IDLE) ? bus.CMD_ARG : rem_q;
  assign step_up   = (state_q == S_IDLE) ? (bus.CMD_OP == OP_INC) : up_q;
  assign at_bound  = step_up ? (tap_q == TAP_MAX) : (tap_q == '0);

  // Next-state and next-output logic; strobes default low every cycle.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    tap_d       = tap_q;
    rem_d       = rem_q;
    up_d        = up_q;
    sat_d       = sat_q;
    cnt_d       = cnt_q;
    ce_d        = 1'b0;
    dinc_d      = 1'b0;
    ld_d        = 1'b0;
    cntin_d     = cntin_q;
    rsp_valid_d = 1'b0;
    rsp_tap_d   = rsp_tap_q;
    rsp_sat_d   = rsp_sat_q;
    rsp_mis_d   = rsp_mis_q;
    go_step     = 1'b0;
    leave       = 1'b0;

    case (state_q)
      S_INIT: begin
        state_d = S_LOAD;
        ld_d    = 1'b1;
        cntin_d = TAP_INIT;
        tap_d   = TAP_INIT;
        ret_d   = RET_IDLE;
      end
      S_IDLE: begin
        if (handshake) begin
          sat_d = 1'b0;
          case (bus.CMD_OP)
            OP_LOAD: begin
              state_d = S_LOAD;
              ld_d    = 1'b1;
              cntin_d = bus.CMD_ARG;
              tap_d   = bus.CMD_ARG;
              ret_d   = RET_RESP;
            end
            OP_INC, OP_DEC: go_step = 1'b1;
            default:        state_d = S_RESP;
          endcase
        end
      end
      S_LOAD: begin
        if (SETTLE_CYCLES == 0) begin
          leave = 1'b1;
        end else begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LAST;
        end
      end
      S_STEP: begin
        // A STEP cycle without a CE pulse is the terminal one (done or saturated).
        if (!ce_q) begin
          state_d = S_RESP;
        end else if (SETTLE_CYCLES == 0) begin
          leave = 1'b1;
        end else begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LAST;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) leave = 1'b1;
        else             cnt_d = cnt_q - 8'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase

    if (leave) begin
      case (ret_q)
        RET_IDLE: state_d = S_IDLE;
        RET_RESP: state_d = S_RESP;
        default:  go_step = 1'b1;
      endcase
    end

    // Decide the step on entry so the CE pulse lands in the STEP cycle itself.
    if (go_step) begin
      state_d = S_STEP;
      rem_d   = step_rem;
      up_d    = step_up;
      ret_d   = RET_STEP;
      if (step_rem != '0 && !at_bound) begin
        ce_d   = 1'b1;
        dinc_d = step_up;
        tap_d  = step_up ? tap_q + 5'd1 : tap_q - 5'd1;
        rem_d  = step_rem - 5'd1;
      end else if (step_rem != '0) begin
        sat_d = 1'b1;
      end
    end

    if (state_d == S_RESP) begin
      rsp_valid_d = 1'b1;
      rsp_tap_d   = tap_d;
      rsp_sat_d   = sat_d;
      rsp_mis_d   = (DLY_CNTVALUEOUT != tap_d);
    end
  end

  assign ready_d = (state_d == S_IDLE);

  always_ff @(posedge C or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= S_INIT;
      ret_q       <= RET_IDLE;
      tap_q       <= '0;
      rem_q       <= '0;
      up_q        <= 1'b0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      ce_q        <= 1'b0;
      dinc_q      <= 1'b0;
      ld_q        <= 1'b0;
      cntin_q     <= TAP_INIT;
      rsp_valid_q <= 1'b0;
      rsp_tap_q   <= '0;
      rsp_sat_q   <= 1'b0;
      rsp_mis_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      tap_q       <= tap_d;
      rem_q       <= rem_d;
      up_q        <= up_d;
      sat_q       <= sat_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      ce_q        <= ce_d;
      dinc_q      <= dinc_d;
      ld_q        <= ld_d;
      cntin_q     <= cntin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tap_q   <= rsp_tap_d;
      rsp_sat_q   <= rsp_sat_d;
      rsp_mis_q   <= rsp_mis_d;
    end
  end

  assign bus.CMD_READY    = ready_q;
  assign bus.RSP_VALID    = rsp_valid_q;
  assign bus.RSP_TAP      = rsp_tap_q;
  assign bus.RSP_SAT      = rsp_sat_q;
  assign bus.RSP_MISMATCH = rsp_mis_q;
  assign DLY_CE           = ce_q;
  assign DLY_INC          = dinc_q;
  assign DLY_LD           = ld_q;
  assign DLY_CNTVALUEIN   = cntin_q;
  assign TAP              = tap_q;

endmodule
